// File: rtl/snitch_testharness.sv
// Simulation fabric between a cluster memory port and its memory models.
// Single-beat requests decode to the boot ROM, the external DRAM model port,
// or the end-of-computation register. One transaction is outstanding at a time.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_*                    cluster request channel (valid/ready)
//   rsp_*                    cluster response channel (valid/ready)
//   dram_req_*               request to the DRAM simulation engine (address rebased)
//   dram_rsp_*               DRAM engine response (no backpressure)
//   eoc_valid_o, eoc_code_o  sticky end-of-computation flag and code
//
// Optional feature: define TESTHARNESS_DRAM_TIMEOUT_EN to add a DRAM watchdog
// that completes a stuck DRAM transaction with an error after TimeoutCycles.

// Preloadable ROM storage, indexed by absolute word address so an external
// hex image load into i_bootrom_sim_mem.mem at the ROM base word works unchanged.
// The write port is tied off in the harness; bus writes never reach it.
module snitch_bootrom_sim_mem #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned BaseWord   = 32'h0001_0000,
  parameter int unsigned Words      = 1024,
  parameter int unsigned IdxWidth   = 17
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  widx_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IdxWidth-1:0]  ridx_i,
  output logic [DataWidth-1:0] rdata_c
);

  logic [DataWidth-1:0] mem [BaseWord:BaseWord+Words-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx_i] <= wdata_i;
  end

  assign rdata_c = mem[ridx_i];

endmodule

module snitch_testharness #(
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 64,
  parameter logic [AddrWidth-1:0] BootromBase   = 32'h0008_0000,
  parameter int unsigned          BootromWords  = 1024,
  parameter logic [AddrWidth-1:0] DramBase      = 32'h8000_0000,
  parameter logic [AddrWidth-1:0] DramSize      = 32'h4000_0000,
  parameter logic [AddrWidth-1:0] EocAddr       = 32'h0200_0000,
  parameter int unsigned          TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   dram_req_valid_o,
  input  logic                   dram_req_ready_i,
  output logic [AddrWidth-1:0]   dram_req_addr_o,
  output logic                   dram_req_write_o,
  output logic [DataWidth-1:0]   dram_req_wdata_o,
  output logic [DataWidth/8-1:0] dram_req_strb_o,
  input  logic                   dram_rsp_valid_i,
  input  logic [DataWidth-1:0]   dram_rsp_rdata_i,
  output logic                   eoc_valid_o,
  output logic [31:0]            eoc_code_o
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffWidth    = $clog2(StrbWidth);
  localparam int unsigned Aw1         = AddrWidth + 1;
  localparam int unsigned RomBaseWord = 32'(BootromBase >> OffWidth);
  localparam int unsigned MemIdxWidth = $clog2(RomBaseWord + BootromWords);
  localparam logic [Aw1-1:0] RomLo    = Aw1'(BootromBase);
  localparam logic [Aw1-1:0] RomHi    = Aw1'(BootromBase) + Aw1'(BootromWords * StrbWidth);
  localparam logic [Aw1-1:0] DramLo   = Aw1'(DramBase);
  localparam logic [Aw1-1:0] DramHi   = Aw1'(DramBase) + Aw1'(DramSize);

  typedef enum logic [1:0] {IDLE, DRAM_REQ, DRAM_WAIT, RSP} state_e;

  state_e                 state_q;
  logic                   lat_write_q;
  logic [Aw1-1:0]         addr_ext;
  logic                   rom_hit, dram_hit, eoc_hit;
  logic [MemIdxWidth-1:0] rom_ridx;
  logic [DataWidth-1:0]   rom_rdata_c;
  logic [DataWidth-1:0]   rsp_rdata_c;
  logic                   rsp_error_c;
  logic                   tmo_hit;

  // Address decode; ranges are half-open and evaluated one bit wider to avoid wrap.
  always_comb begin
    addr_ext = {1'b0, req_addr_i};
    rom_hit  = (addr_ext >= RomLo) && (addr_ext < RomHi);
    dram_hit = (addr_ext >= DramLo) && (addr_ext < DramHi);
    eoc_hit  = req_addr_i[AddrWidth-1:OffWidth] == EocAddr[AddrWidth-1:OffWidth];
    rom_ridx = rom_hit ? MemIdxWidth'(req_addr_i[AddrWidth-1:OffWidth])
                       : MemIdxWidth'(RomBaseWord);
  end

  snitch_bootrom_sim_mem #(
    .DataWidth (DataWidth),
    .BaseWord  (RomBaseWord),
    .Words     (BootromWords),
    .IdxWidth  (MemIdxWidth)
  ) i_bootrom_sim_mem (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .widx_i  (MemIdxWidth'(RomBaseWord)),
    .wdata_i (DataWidth'(0)),
    .ridx_i  (rom_ridx),
    .rdata_c (rom_rdata_c)
  );

  // Response for targets answered locally (ROM, EOC, unmapped).
  always_comb begin
    rsp_rdata_c = '0;
    rsp_error_c = 1'b1;
    if (rom_hit) begin
      rsp_error_c = req_write_i;
      if (!req_write_i) rsp_rdata_c = rom_rdata_c;
    end else if (eoc_hit) begin
      rsp_error_c = 1'b0;
      if (!req_write_i) rsp_rdata_c = DataWidth'(eoc_code_o);
    end
  end

`ifdef TESTHARNESS_DRAM_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] tmo_cnt_q;

  // Watchdog: cleared on entry to DRAM_REQ, counts while a DRAM access is pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == DRAM_REQ) || (state_q == DRAM_WAIT)) begin
      tmo_cnt_q <= tmo_cnt_q + CntWidth'(1);
    end
  end

  assign tmo_hit = tmo_cnt_q >= CntWidth'(TimeoutCycles - 1);
`else
  assign tmo_hit = 1'b0;
`endif

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      lat_write_q      <= 1'b0;
      req_ready_o      <= 1'b1;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= '0;
      rsp_error_o      <= 1'b0;
      dram_req_valid_o <= 1'b0;
      dram_req_addr_o  <= '0;
      dram_req_write_o <= 1'b0;
      dram_req_wdata_o <= '0;
      dram_req_strb_o  <= '0;
      eoc_valid_o      <= 1'b0;
      eoc_code_o       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            if (dram_hit) begin
              state_q          <= DRAM_REQ;
              lat_write_q      <= req_write_i;
              dram_req_valid_o <= 1'b1;
              dram_req_addr_o  <= req_addr_i - DramBase;
              dram_req_write_o <= req_write_i;
              dram_req_wdata_o <= req_wdata_i;
              dram_req_strb_o  <= req_strb_i;
            end else begin
              state_q     <= RSP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rsp_rdata_c;
              rsp_error_o <= rsp_error_c;
              if (eoc_hit && req_write_i) begin
                eoc_valid_o <= 1'b1;
                eoc_code_o  <= req_wdata_i[31:0];
              end
            end
          end
        end
        DRAM_REQ: begin
          if (dram_req_ready_i) begin
            state_q          <= DRAM_WAIT;
            dram_req_valid_o <= 1'b0;
          end else if (tmo_hit) begin
            state_q          <= RSP;
            dram_req_valid_o <= 1'b0;
            rsp_valid_o      <= 1'b1;
            rsp_rdata_o      <= '0;
            rsp_error_o      <= 1'b1;
          end
        end
        DRAM_WAIT: begin
          if (dram_rsp_valid_i) begin
            state_q     <= RSP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= lat_write_q ? '0 : dram_rsp_rdata_i;
            rsp_error_o <= 1'b0;
          end else if (tmo_hit) begin
            state_q     <= RSP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snitch_testharness.sv
// Randomized bench for snitch_testharness: a behavioural memory-map model
// (ROM image, EOC register, DRAM engine contents) predicts every response.
module tb_snitch_testharness;

  localparam logic [31:0] ROM_BASE  = 32'h0008_0000;
  localparam int          ROM_WORDS = 1024;
  localparam logic [31:0] DRAM_BASE = 32'h8000_0000;
  localparam logic [32:0] DRAM_END  = 33'h0_C000_0000;
  localparam logic [31:0] EOC_ADDR  = 32'h0200_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_strb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        dram_req_valid_o;
  logic        dram_req_ready_i = 1'b0;
  logic [31:0] dram_req_addr_o;
  logic        dram_req_write_o;
  logic [63:0] dram_req_wdata_o;
  logic [7:0]  dram_req_strb_o;
  logic        dram_rsp_valid_i = 1'b0;
  logic [63:0] dram_rsp_rdata_i = '0;
  logic        eoc_valid_o;
  logic [31:0] eoc_code_o;

  snitch_testharness dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_write_i      (req_write_i),
    .req_wdata_i      (req_wdata_i),
    .req_strb_i       (req_strb_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_error_o      (rsp_error_o),
    .dram_req_valid_o (dram_req_valid_o),
    .dram_req_ready_i (dram_req_ready_i),
    .dram_req_addr_o  (dram_req_addr_o),
    .dram_req_write_o (dram_req_write_o),
    .dram_req_wdata_o (dram_req_wdata_o),
    .dram_req_strb_o  (dram_req_strb_o),
    .dram_rsp_valid_i (dram_rsp_valid_i),
    .dram_rsp_rdata_i (dram_rsp_rdata_i),
    .eoc_valid_o      (eoc_valid_o),
    .eoc_code_o       (eoc_code_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference state
  logic [63:0] rom_model [ROM_WORDS];
  logic [63:0] dram_mem  [logic [31:0]];
  logic        m_eoc_valid = 1'b0;
  logic [31:0] m_eoc_code  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] strb_merge(input logic [63:0] old, input logic [63:0] nw,
                                             input logic [7:0] st);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One complete transaction; lat < 0 picks a random DRAM engine latency.
  task automatic txn(input logic [31:0] a, input logic w, input logic [63:0] wd,
                     input logic [7:0] st, input int lat, input int hold);
    logic [32:0] ax;
    logic        is_rom, is_dram, is_eoc;
    logic [63:0] exp_rd, eng_rd;
    logic        exp_err;
    logic [31:0] woff;
    int          l;
    ax      = {1'b0, a};
    is_rom  = (ax >= {1'b0, ROM_BASE}) && (ax < {1'b0, ROM_BASE} + 33'(ROM_WORDS * 8));
    is_dram = (ax >= {1'b0, DRAM_BASE}) && (ax < DRAM_END);
    is_eoc  = (a >> 3) == (EOC_ADDR >> 3);
    exp_rd  = '0;
    exp_err = 1'b1;
    if (is_rom) begin
      if (!w) begin
        exp_rd  = rom_model[(a - ROM_BASE) / 8];
        exp_err = 1'b0;
      end
    end else if (is_eoc) begin
      exp_err = 1'b0;
      if (w) begin
        m_eoc_valid = 1'b1;
        m_eoc_code  = wd[31:0];
      end else begin
        exp_rd = {32'h0, m_eoc_code};
      end
    end

    // Occasionally a stray engine response while idle; it must be ignored.
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk_i);
      dram_rsp_valid_i = 1'b1;
      dram_rsp_rdata_i = {$urandom, $urandom};
      @(negedge clk_i);
      dram_rsp_valid_i = 1'b0;
      check("stray_dram_rsp", rsp_valid_o, 1'b0);
    end

    @(negedge clk_i);
    check("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    req_wdata_i = wd;
    req_strb_i  = st;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = {$urandom, $urandom};
    req_strb_i  = 8'($urandom);
    check("req_ready_busy", req_ready_o, 1'b0);

    if (is_dram) begin
      check("dram_req_valid", dram_req_valid_o, 1'b1);
      check("dram_req_addr", dram_req_addr_o, a - DRAM_BASE);
      check("dram_req_write", dram_req_write_o, w);
      check("dram_req_wdata", dram_req_wdata_o, wd);
      check("dram_req_strb", dram_req_strb_o, st);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk_i);
        check("dram_req_hold", dram_req_valid_o, 1'b1);
      end
      dram_req_ready_i = 1'b1;
      @(negedge clk_i);
      dram_req_ready_i = 1'b0;
      check("dram_req_drop", dram_req_valid_o, 1'b0);
      l = (lat < 0) ? int'($urandom_range(0, 5)) : lat;
      repeat (l) begin
        @(negedge clk_i);
        check("dram_wait_no_rsp", rsp_valid_o, 1'b0);
      end
      woff   = (a - DRAM_BASE) >> 3;
      eng_rd = dram_mem.exists(woff) ? dram_mem[woff] : {a, ~a};
      if (w) dram_mem[woff] = strb_merge(eng_rd, wd, st);
      dram_rsp_valid_i = 1'b1;
      dram_rsp_rdata_i = w ? {$urandom, $urandom} : eng_rd;
      exp_rd  = w ? 64'h0 : eng_rd;
      exp_err = 1'b0;
      @(negedge clk_i);
      dram_rsp_valid_i = 1'b0;
      dram_rsp_rdata_i = {$urandom, $urandom};
    end

    check("rsp_valid", rsp_valid_o, 1'b1);
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    check("rsp_error", rsp_error_o, exp_err);
    check("eoc_valid", eoc_valid_o, m_eoc_valid);
    check("eoc_code", eoc_code_o, m_eoc_code);
    repeat (hold) begin
      @(negedge clk_i);
      check("rsp_hold_valid", rsp_valid_o, 1'b1);
      check("rsp_hold_rdata", rsp_rdata_o, exp_rd);
      check("rsp_hold_error", rsp_error_o, exp_err);
      check("rsp_hold_ready", req_ready_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_done_valid", rsp_valid_o, 1'b0);
    check("rsp_done_ready", req_ready_o, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1: return ROM_BASE + 32'($urandom_range(0, ROM_WORDS - 1) * 8) + 32'($urandom_range(0, 7));
      2: case ($urandom_range(0, 2))
           0: return ROM_BASE + 32'(ROM_WORDS * 8 - 1);
           1: return ROM_BASE + 32'(ROM_WORDS * 8);
           default: return ROM_BASE - 32'd8;
         endcase
      3, 4: return DRAM_BASE + ($urandom % 32'h4000_0000);
      5: case ($urandom_range(0, 2))
           0: return 32'hBFFF_FFFF;
           1: return 32'hC000_0000;
           default: return 32'h7FFF_FFF8;
         endcase
      6: return EOC_ADDR + 32'($urandom_range(0, 7));
      7: return ($urandom_range(0, 1) == 0) ? EOC_ADDR + 32'd8 : EOC_ADDR - 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] v;
    logic [31:0] ra;
    // Backdoor ROM preload at the absolute word index the harness exposes.
    for (int i = 0; i < ROM_WORDS; i++) begin
      v = (i == 0) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom};
      rom_model[i] = v;
      dut.i_bootrom_sim_mem.mem[32'h0001_0000 + i] = v;
    end

    #12;
    check("rst_req_ready", req_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_rdata", rsp_rdata_o, 64'h0);
    check("rst_rsp_error", rsp_error_o, 1'b0);
    check("rst_dram_valid", dram_req_valid_o, 1'b0);
    check("rst_dram_addr", dram_req_addr_o, 32'h0);
    check("rst_eoc_valid", eoc_valid_o, 1'b0);
    check("rst_eoc_code", eoc_code_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases
    txn(32'h0008_0000, 1'b0, 64'h0, 8'h00, -1, 0);
    txn(32'h8000_0010, 1'b0, 64'h0, 8'h00, 5, 0);
    txn(32'h0200_0000, 1'b1, 64'h1, 8'hFF, -1, 0);
    txn(32'h0200_0000, 1'b0, 64'h0, 8'h00, -1, 0);
    txn(32'h0008_0008, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1, 0);
    txn(32'h0100_0000, 1'b0, 64'h0, 8'h00, -1, 0);
    txn(32'h0008_0008, 1'b0, 64'h0, 8'h00, -1, 3);
    txn(32'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, -1, 3);
    txn(32'h8000_0010, 1'b0, 64'h0, 8'h00, 0, 0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      ra = rand_addr();
      txn(ra, ($urandom_range(0, 9) < 4), {$urandom, $urandom}, 8'($urandom),
          -1, int'($urandom_range(0, 3)));
    end

    // Make sure EOC is set so the reset check below is meaningful.
    txn(EOC_ADDR, 1'b1, 64'hA5A5_0000_C0DE_0042, 8'hFF, -1, 0);

    // Reset while a DRAM read sits in DRAM_WAIT.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = DRAM_BASE + 32'h100;
    req_write_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    dram_req_ready_i = 1'b1;
    @(negedge clk_i);
    dram_req_ready_i = 1'b0;
    check("mid_dram_wait", dram_req_valid_o, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid_o, 1'b0);
    check("abort_dram_valid", dram_req_valid_o, 1'b0);
    check("abort_eoc_valid", eoc_valid_o, 1'b0);
    check("abort_eoc_code", eoc_code_o, 32'h0);
    check("abort_req_ready", req_ready_o, 1'b1);
    check("abort_rsp_rdata", rsp_rdata_o, 64'h0);
    m_eoc_valid = 1'b0;
    m_eoc_code  = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Recovery after the abort; ROM contents survive reset.
    txn(32'h0008_0000, 1'b0, 64'h0, 8'h00, -1, 0);
    txn(ROM_BASE + 32'(ROM_WORDS * 8 - 8), 1'b0, 64'h0, 8'h00, -1, 0);
    txn(EOC_ADDR + 32'd4, 1'b0, 64'h0, 8'h00, -1, 0);

    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
